// File: rtl/mantle_concat_pkg.sv
// Shared types and default sizing for the mantle_concat three-source frame serialiser.
package mantle_concat_pkg;

   typedef enum logic [1:0] {
      S_IN0 = 2'd0,
      S_IN1 = 2'd1,
      S_IN2 = 2'd2
   } state_e;

   localparam int DEF_W  = 32;
   localparam int DEF_N0 = 9;
   localparam int DEF_N1 = 6;
   localparam int DEF_N2 = 7;

   // Source order within a frame wraps back to source 0 after source 2.
   function automatic state_e next_src(input state_e s);
      state_e n;
      case (s)
         S_IN0:   n = S_IN1;
         S_IN1:   n = S_IN2;
         default: n = S_IN0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mantle_concat_outreg.sv
// Single-entry output register with valid/ready hold; abort drops the held element.
module mantle_concat_outreg #(
   parameter int W  = 32,
   parameter int IW = 5
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          abort,
   input  logic          load,
   input  logic [W-1:0]  load_data,
   input  logic [IW-1:0] load_idx,
   input  logic          load_last,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [W-1:0]  out_data,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          free
);

   logic          valid_q, valid_d;
   logic [W-1:0]  data_q, data_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          last_q, last_d;

   // Payload registers only move on a load, so a stalled or dropped element leaves them intact.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      idx_d   = idx_q;
      last_d  = last_q;
      free    = !valid_q || out_ready;
      if (abort) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         idx_d   = load_idx;
         last_d  = load_last;
      end else if (free) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_idx   = idx_q;
   assign out_last  = last_q;

endmodule

// File: rtl/mantle_concat_seq.sv
// Serialises N0 elements of source 0, N1 of source 1 and N2 of source 2 into one frame stream.
// Define MANTLE_CONCAT_SEQ_FRAMECNT_EN to add the 16-bit frame_cnt output.
module mantle_concat_seq
   import mantle_concat_pkg::*;
#(
   parameter  int W  = DEF_W,
   parameter  int N0 = DEF_N0,
   parameter  int N1 = DEF_N1,
   parameter  int N2 = DEF_N2,
   localparam int NT = N0 + N1 + N2,
   localparam int IW = $clog2(NT)
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          abort,
   input  logic          in0_valid,
   input  logic [W-1:0]  in0_data,
   output logic          in0_ready,
   input  logic          in1_valid,
   input  logic [W-1:0]  in1_data,
   output logic          in1_ready,
   input  logic          in2_valid,
   input  logic [W-1:0]  in2_data,
   output logic          in2_ready,
   output logic          out_valid,
   output logic [W-1:0]  out_data,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   input  logic          out_ready
`ifdef MANTLE_CONCAT_SEQ_FRAMECNT_EN
   ,
   output logic [15:0]   frame_cnt
`endif
);

   state_e        state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;

   logic          free;
   logic          accept_ok;
   logic          sel_valid;
   logic [W-1:0]  sel_data;
   logic [IW-1:0] sel_off;
   logic [IW-1:0] sel_cnt_max;
   logic          xfer;
   logic [IW-1:0] load_idx;
   logic          load_last;

   // Steer the active source onto the shared load path along with its frame offset.
   always_comb begin
      sel_valid   = 1'b0;
      sel_data    = '0;
      sel_off     = '0;
      sel_cnt_max = '0;
      case (state_q)
         S_IN0: begin
            sel_valid   = in0_valid;
            sel_data    = in0_data;
            sel_off     = '0;
            sel_cnt_max = IW'(N0 - 1);
         end
         S_IN1: begin
            sel_valid   = in1_valid;
            sel_data    = in1_data;
            sel_off     = IW'(N0);
            sel_cnt_max = IW'(N1 - 1);
         end
         S_IN2: begin
            sel_valid   = in2_valid;
            sel_data    = in2_data;
            sel_off     = IW'(N0 + N1);
            sel_cnt_max = IW'(N2 - 1);
         end
         default: ;
      endcase
   end

   // Readies are gated by reset as well so nothing is offered while the block is held in reset.
   always_comb begin
      accept_ok = free && !abort && arst_n;
      in0_ready = (state_q == S_IN0) && accept_ok;
      in1_ready = (state_q == S_IN1) && accept_ok;
      in2_ready = (state_q == S_IN2) && accept_ok;
      xfer      = sel_valid && accept_ok;
      load_idx  = sel_off + cnt_q;
      load_last = (load_idx == IW'(NT - 1));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (abort) begin
         state_d = S_IN0;
         cnt_d   = '0;
      end else if (xfer) begin
         if (cnt_q == sel_cnt_max) begin
            cnt_d   = '0;
            state_d = next_src(state_q);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_IN0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   mantle_concat_outreg #(
      .W  (W),
      .IW (IW)
   ) u_outreg (
      .clk       (clk),
      .arst_n    (arst_n),
      .abort     (abort),
      .load      (xfer),
      .load_data (sel_data),
      .load_idx  (load_idx),
      .load_last (load_last),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .free      (free)
   );

`ifdef MANTLE_CONCAT_SEQ_FRAMECNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Counts frames as they leave the sink side, so an abort never rewinds it.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (out_valid && out_ready && out_last) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_mantle_concat_seq.sv
// Self-checking bench for mantle_concat_seq: table-driven frame, directed corner cases, random traffic.
module tb_mantle_concat_seq;
   import mantle_concat_pkg::*;

   localparam int W  = 32;
   localparam int N0 = 9;
   localparam int N1 = 6;
   localparam int N2 = 7;
   localparam int NT = N0 + N1 + N2;
   localparam int IW = $clog2(NT);

   logic          clk;
   logic          arst_n;
   logic          abort;
   logic          in0_valid, in1_valid, in2_valid;
   logic [W-1:0]  in0_data, in1_data, in2_data;
   logic          in0_ready, in1_ready, in2_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic [IW-1:0] out_idx;
   logic          out_last;
   logic          out_ready;
`ifdef MANTLE_CONCAT_SEQ_FRAMECNT_EN
   logic [15:0]   frame_cnt;
`endif

   typedef struct {
      logic [2:0]    vld;
      logic          ordy;
      logic          abrt;
      logic [2:0]    exp_rdy;
      logic          exp_ov;
      logic [IW-1:0] exp_idx;
      logic [W-1:0]  exp_data;
      logic          exp_last;
   } vec_t;

   vec_t tbl[NT+1];
   vec_t nil_row;

   int n_vec;
   int n_err;
   int hs_cnt;

   // Reference model: position of the next accepted element in the frame plus the output register image.
   int            m_pos;
   logic          m_valid;
   logic [W-1:0]  m_data;
   logic [IW-1:0] m_idx;
   logic          m_last;
   int            cons[3];
   logic [15:0]   m_fc;

   mantle_concat_seq dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .abort     (abort),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .in2_valid (in2_valid),
      .in2_data  (in2_data),
      .in2_ready (in2_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_ready (out_ready)
`ifdef MANTLE_CONCAT_SEQ_FRAMECNT_EN
      ,
      .frame_cnt (frame_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int src_of(input int p);
      if (p < N0) return 0;
      if (p < N0 + N1) return 1;
      return 2;
   endfunction

   function automatic int off_of(input int s);
      if (s == 0) return 0;
      if (s == 1) return N0;
      return N0 + N1;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Directed data is 100*k + (elements already taken from source k); random mode uses $urandom.
   task automatic apply_stimulus(input logic [2:0] vld, input logic ordy, input logic abrt, input bit rnd);
      {in2_valid, in1_valid, in0_valid} = vld;
      out_ready = ordy;
      abort     = abrt;
      if (rnd) begin
         in0_data = $urandom;
         in1_data = $urandom;
         in2_data = $urandom;
      end else begin
         in0_data = W'(cons[0]);
         in1_data = W'(100 + cons[1]);
         in2_data = W'(200 + cons[2]);
      end
   endtask

   task automatic model_reset();
      m_pos   = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_idx   = '0;
      m_last  = 1'b0;
      cons[0] = 0;
      cons[1] = 0;
      cons[2] = 0;
      m_fc    = '0;
   endtask

   // One clock: check readies before the edge, advance the model, check outputs after the edge.
   task automatic step(input bit use_row, input vec_t row);
      logic [2:0]   exp_rdy;
      logic [2:0]   vld;
      logic         free;
      int           s;
      logic [W-1:0] d;
      #1;
      free    = !m_valid || out_ready;
      s       = src_of(m_pos);
      exp_rdy = '0;
      if (free && !abort) exp_rdy[s] = 1'b1;
      check_output("in_ready", {in2_ready, in1_ready, in0_ready}, exp_rdy);
      if (use_row) check_output("row_ready", {in2_ready, in1_ready, in0_ready}, row.exp_rdy);
      if (out_valid && out_ready) hs_cnt++;
      if (m_valid && out_ready && m_last) m_fc = m_fc + 16'd1;
      vld = {in2_valid, in1_valid, in0_valid};
      d   = (s == 0) ? in0_data : (s == 1) ? in1_data : in2_data;
      if (abort) begin
         m_valid = 1'b0;
         m_pos   = 0;
      end else if (vld[s] && exp_rdy[s]) begin
         m_valid = 1'b1;
         m_data  = d;
         m_idx   = IW'(m_pos);
         m_last  = (m_pos == NT - 1);
         cons[s]++;
         m_pos   = (m_pos + 1) % NT;
      end else if (free) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check_output("out_valid", out_valid, m_valid);
      check_output("out_data", out_data, m_data);
      check_output("out_idx", out_idx, m_idx);
      check_output("out_last", out_last, m_last);
`ifdef MANTLE_CONCAT_SEQ_FRAMECNT_EN
      check_output("frame_cnt", frame_cnt, m_fc);
`endif
      if (use_row) begin
         check_output("row_out_valid", out_valid, row.exp_ov);
         check_output("row_out_idx", out_idx, row.exp_idx);
         check_output("row_out_data", out_data, row.exp_data);
         check_output("row_out_last", out_last, row.exp_last);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      apply_stimulus(3'b000, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      model_reset();
      arst_n = 1'b1;
   endtask

   task automatic run_steps(input int n, input logic [2:0] vld, input logic ordy);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(vld, ordy, 1'b0, 1'b0);
         step(1'b0, nil_row);
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      hs_cnt  = 0;
      nil_row = '{default: '0};
      model_reset();

      for (int c = 0; c < NT; c++) begin
         tbl[c].vld      = 3'b111;
         tbl[c].ordy     = 1'b1;
         tbl[c].abrt     = 1'b0;
         tbl[c].exp_rdy  = 3'b001 << src_of(c);
         tbl[c].exp_ov   = 1'b1;
         tbl[c].exp_idx  = IW'(c);
         tbl[c].exp_data = W'(100 * src_of(c) + c - off_of(src_of(c)));
         tbl[c].exp_last = (c == NT - 1);
      end
      tbl[NT].vld      = 3'b000;
      tbl[NT].ordy     = 1'b1;
      tbl[NT].abrt     = 1'b0;
      tbl[NT].exp_rdy  = 3'b001;
      tbl[NT].exp_ov   = 1'b0;
      tbl[NT].exp_idx  = IW'(NT - 1);
      tbl[NT].exp_data = W'(206);
      tbl[NT].exp_last = 1'b1;

      // Reset values, including readies forced low while reset is held.
      arst_n = 1'b0;
      apply_stimulus(3'b111, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check_output("rst_out_valid", out_valid, 1'b0);
      check_output("rst_out_data", out_data, '0);
      check_output("rst_out_idx", out_idx, '0);
      check_output("rst_out_last", out_last, 1'b0);
      check_output("rst_ready", {in2_ready, in1_ready, in0_ready}, 3'b000);
      @(negedge clk);
      do_reset();

      $display("[TB] full frame from table");
      for (int r = 0; r <= NT; r++) begin
         apply_stimulus(tbl[r].vld, tbl[r].ordy, tbl[r].abrt, 1'b0);
         step(1'b1, tbl[r]);
      end

      $display("[TB] sink stall at idx 3");
      do_reset();
      hs_cnt = 0;
      run_steps(4, 3'b111, 1'b1);
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(3'b111, 1'b0, 1'b0, 1'b0);
         #1;
         check_output("stall_ready", {in2_ready, in1_ready, in0_ready}, 3'b000);
         step(1'b0, nil_row);
         check_output("stall_idx", out_idx, IW'(3));
         check_output("stall_data", out_data, W'(3));
      end
      run_steps(NT - 4, 3'b111, 1'b1);
      run_steps(1, 3'b000, 1'b1);
      check_output("stall_handshakes", hs_cnt, NT);

      $display("[TB] foreign valids during source 0");
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(3'b110, 1'b1, 1'b0, 1'b0);
         #1;
         check_output("foreign_ready", {in2_ready, in1_ready}, 2'b00);
         step(1'b0, nil_row);
      end
      for (int i = 0; i < N0; i++) begin
         apply_stimulus(3'b111, 1'b1, 1'b0, 1'b0);
         #1;
         check_output("foreign_ready_s0", {in2_ready, in1_ready}, 2'b00);
         step(1'b0, nil_row);
      end
      apply_stimulus(3'b111, 1'b1, 1'b0, 1'b0);
      #1;
      check_output("src1_ready", {in2_ready, in1_ready, in0_ready}, 3'b010);
      step(1'b0, nil_row);
      check_output("src1_first_data", out_data, W'(100));

      $display("[TB] abort at idx 12");
      do_reset();
      run_steps(12, 3'b111, 1'b1);
      apply_stimulus(3'b111, 1'b1, 1'b1, 1'b0);
      #1;
      check_output("abort_ready", {in2_ready, in1_ready, in0_ready}, 3'b000);
      step(1'b0, nil_row);
      check_output("abort_out_valid", out_valid, 1'b0);
      apply_stimulus(3'b111, 1'b1, 1'b0, 1'b0);
      step(1'b0, nil_row);
      check_output("abort_restart_idx", out_idx, IW'(0));
      check_output("abort_restart_data", out_data, W'(9));
      check_output("abort_restart_valid", out_valid, 1'b1);

      $display("[TB] reset at idx 17");
      do_reset();
      run_steps(17, 3'b111, 1'b1);
      apply_stimulus(3'b111, 1'b1, 1'b0, 1'b0);
      #2;
      arst_n = 1'b0;
      #1;
      check_output("mid_rst_valid", out_valid, 1'b0);
      check_output("mid_rst_data", out_data, '0);
      check_output("mid_rst_idx", out_idx, '0);
      check_output("mid_rst_last", out_last, 1'b0);
      check_output("mid_rst_ready", {in2_ready, in1_ready, in0_ready}, 3'b000);
      repeat (2) @(negedge clk);
      model_reset();
      arst_n = 1'b1;
      apply_stimulus(3'b111, 1'b1, 1'b0, 1'b0);
      step(1'b0, nil_row);
      check_output("post_rst_idx", out_idx, IW'(0));
      check_output("post_rst_data", out_data, W'(0));
      run_steps(NT - 1, 3'b111, 1'b1);

`ifdef MANTLE_CONCAT_SEQ_FRAMECNT_EN
      $display("[TB] frame counter");
      do_reset();
      run_steps(3 * NT, 3'b111, 1'b1);
      run_steps(1, 3'b000, 1'b1);
      check_output("frame_cnt_3", frame_cnt, 16'd3);
      force dut.frame_cnt_q = 16'hFFFE;
      #1;
      release dut.frame_cnt_q;
      m_fc = 16'hFFFE;
      run_steps(2 * NT, 3'b111, 1'b1);
      run_steps(1, 3'b000, 1'b1);
      check_output("frame_cnt_wrap", frame_cnt, 16'h0000);
`endif

      $display("[TB] random traffic");
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         apply_stimulus({($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                         ($urandom_range(0, 3) != 0)},
                        ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0), 1'b1);
         step(1'b0, nil_row);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mantle_concat_seq.md
MANTLE_CONCAT_SEQ -- requirements
Module: mantle_concat_seq

Interface
REQ-001 Parameters SHALL be, one per line:
  W   32  element width in bits
  N0  9   elements per frame taken from source 0
  N1  6   elements per frame taken from source 1
  N2  7   elements per frame taken from source 2
REQ-002 N0, N1 and N2 SHALL each be >= 1; NT = N0+N1+N2 (default 22); IW = clog2(NT) (default 5).
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk        in   1   single clock, rising edge
  arst_n     in   1   asynchronous reset, active-low
  abort      in   1   synchronous frame abort
  in0_valid  in   1   source 0 element valid
  in0_data   in   W   source 0 element
  in0_ready  out  1   source 0 element accepted
  in1_valid / in1_data / in1_ready  same as source 0, for source 1
  in2_valid / in2_data / in2_ready  same as source 0, for source 2
  out_valid  out  1   output element valid
  out_data   out  W   output element
  out_idx    out  IW  position of the element in the frame, 0..NT-1
  out_last   out  1   high when out_idx == NT-1
  out_ready  in   1   sink accepts the output element
REQ-004 The block SHALL use one clock (clk); reset (arst_n) SHALL be asynchronous and active-low.

Function
REQ-005 The block SHALL serialise one frame per pass: N0 elements from source 0, then N1 from source 1, then N2 from source 2, then restart at source 0.
REQ-006 The FSM SHALL have the states S_IN0, S_IN1 and S_IN2. A local counter cnt SHALL track the element position within the current source.
REQ-007 The output register is free when free = !out_valid || out_ready.
REQ-008 ink_ready SHALL be (state == S_INk) && free && !abort. It SHALL be combinational, and the ready of every non-selected source SHALL be 0.
REQ-009 A transfer occurs when the selected source's valid and ready are both 1. On the next edge: out_data SHALL take ink_data, out_idx SHALL take the offset of source k plus cnt, out_last SHALL take (out_idx == NT-1), and out_valid SHALL be 1.
REQ-010 Latency from input transfer to out_valid SHALL be exactly 1 cycle. Throughput SHALL be 1 element per cycle when out_ready is held at 1.
REQ-011 If the output is free and no input transfer occurs, out_valid SHALL go to 0 on the next edge. While out_valid && !out_ready, all output registers SHALL hold.
REQ-012 On each transfer with cnt == Nk-1, cnt SHALL return to 0 and the state SHALL advance S_IN0 -> S_IN1 -> S_IN2 -> S_IN0. Otherwise cnt SHALL increment.
REQ-013 Valid on a non-selected source SHALL be ignored. Its data SHALL NOT be consumed.
REQ-014 When abort is high at an edge: state SHALL go to S_IN0, cnt SHALL go to 0, and out_valid SHALL go to 0. Abort SHALL override any transfer in the same cycle, and the element held in the output register SHALL be dropped.
REQ-015 No other state or register SHALL change except as specified above.

Reset
REQ-016 While arst_n is low: state SHALL be S_IN0, cnt 0, out_valid 0, out_data 0, out_idx 0, out_last 0. All ready outputs SHALL be 0 while arst_n is low.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame. After release, the first element accepted SHALL come from source 0 with out_idx 0.

Configuration
REQ-018 With MANTLE_CONCAT_SEQ_FRAMECNT_EN defined, the block SHALL add a 16-bit output port frame_cnt.
  - frame_cnt SHALL reset to 0.
  - It SHALL increment on each output handshake (out_valid && out_ready) where out_last is 1.
  - It SHALL wrap from 0xFFFF to 0x0000.
  - It SHALL be unaffected by abort.
REQ-019 Without MANTLE_CONCAT_SEQ_FRAMECNT_EN defined, the frame_cnt port and its register SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-020 A shared package mantle_concat_pkg SHALL hold the state enum (S_IN0, S_IN1, S_IN2), the default W, and the default N0, N1 and N2 constants.
REQ-021 The output register plus its hold logic SHALL be one sub-module, mantle_concat_outreg. All other logic SHALL be flat.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  1. All valid, out_ready=1, source k sends 100*k+i -> 22 outputs in one frame, out_idx 0..21, data 0..8, 100..105, 200..206, out_last only at idx 21, no bubbles.
  2. Hold out_ready=0 for 5 cycles at idx 3 -> out_data/out_idx stable, all readies 0, no element lost or duplicated.
  3. in1_valid and in2_valid high during S_IN0 -> in1_ready and in2_ready stay 0 until the state reaches the matching source.
  4. Abort at idx 12 while a transfer is pending -> next cycle out_valid=0, and the next accepted element has out_idx 0 from source 0.
  5. arst_n low at idx 17 -> all outputs 0 immediately; after release the frame restarts at idx 0.
  6. With FRAMECNT_EN, 3 frames -> frame_cnt=3; preload near the limit and check the wrap from 0xFFFF to 0.
